alu_issue_stage: RTL and testbench

Decode/issue stage that drives the RV32I ALU: it decodes an instruction, builds the operand pair and the 4-bit ALU op code, and registers them for the execute stage. It sits between register-file read and the ALU and uses valid/ready handshakes on both sides. A 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/issue_skid_buffer.sv | 115 +++++++++++
 rtl/alu_issue_stage.sv | 139 +++++++++++++
 tb/tb_alu_issue_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU op codes, RV32I opcodes and the
// issue payload carried from decode to execute.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_e         op;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
  } issue_pkt_t;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/issue_skid_buffer.sv
// Two-entry skid buffer over issue_pkt_t. Ready is registered from the
// occupancy state, so out_ready_i never reaches in_ready_o combinationally.
module issue_skid_buffer
  import alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  issue_pkt_t in_pkt_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output issue_pkt_t out_pkt_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_e;

  skid_state_e r_state;
  skid_state_e w_state_nxt;
  issue_pkt_t  r_out_pkt;
  issue_pkt_t  r_skid_pkt;
  logic        r_out_valid;
  logic        r_in_ready;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_load_in_to_out;
  logic        w_load_in_to_skid;
  logic        w_load_skid_to_out;

  assign w_in_fire  = in_valid_i && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready_i;

  // Next occupancy and which register gets loaded; flush wins over everything.
  always_comb begin
    w_state_nxt        = r_state;
    w_load_in_to_out   = 1'b0;
    w_load_in_to_skid  = 1'b0;
    w_load_skid_to_out = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt      = S_ONE;
            w_load_in_to_out = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_state_nxt      = S_ONE;
            w_load_in_to_out = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt       = S_TWO;
            w_load_in_to_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end else begin
            w_state_nxt = S_ONE;
          end
        end
        S_TWO: begin
          if (w_out_fire) begin
            w_state_nxt        = S_ONE;
            w_load_skid_to_out = 1'b1;
          end else begin
            w_state_nxt = S_TWO;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // State, handshake flags and payload registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_pkt   <= '0;
      r_skid_pkt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_in_ready  <= (w_state_nxt != S_TWO);
      if (w_load_in_to_out) begin
        r_out_pkt <= in_pkt_i;
      end else if (w_load_skid_to_out) begin
        r_out_pkt <= r_skid_pkt;
      end else begin
        r_out_pkt <= r_out_pkt;
      end
      if (w_load_in_to_skid) begin
        r_skid_pkt <= in_pkt_i;
      end else begin
        r_skid_pkt <= r_skid_pkt;
      end
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_pkt_o   = r_out_pkt;

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I ALU-class decode and issue: builds operands and op code from the
// instruction and hands them to execute through a two-entry skid buffer.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [OP_WIDTH-1:0]   op_o,
  output logic [4:0]            rd_o,
  output logic                  we_o,
  output logic                  illegal_o
);

  function automatic issue_pkt_t decode_instr(
    input logic [31:0]     instr,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] rs2
  );
    issue_pkt_t p;
    logic       legal;
    logic [2:0] f3;
    logic [6:0] f7;
    alu_op_e    base_op;
    f3 = instr[14:12];
    f7 = instr[31:25];
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      3'b111:  base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase
    p     = '0;
    p.rd  = instr[11:7];
    p.op  = ALU_ADD;
    legal = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        p.a = rs1;
        p.b = rs2;
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          p.op  = base_op;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          legal = 1'b1;
          p.op  = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          legal = 1'b1;
          p.op  = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        p.a  = rs1;
        p.b  = {{(XLEN-12){instr[31]}}, instr[31:20]};
        p.op = base_op;
        // Shift immediates reuse imm[11:5] as a funct7-style qualifier.
        if (f3 == 3'b001) begin
          legal = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          p.op  = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
        end else begin
          legal = 1'b1;
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        p.a   = '0;
        p.b   = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        p.a   = pc;
        p.b   = {instr[31:12], 12'b0};
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    if (!legal) begin
      p.a  = '0;
      p.b  = '0;
      p.op = ALU_ADD;
    end else if (is_shift_op(p.op)) begin
      p.b[XLEN-1:5] = '0;
    end else begin
      p.b = p.b;
    end
    p.illegal = !legal;
    p.we      = legal && (p.rd != 5'd0);
    return p;
  endfunction

  issue_pkt_t w_dec_pkt;
  issue_pkt_t w_out_pkt;

  assign w_dec_pkt = decode_instr(instr_i, pc_i, rs1_data_i, rs2_data_i);

  issue_skid_buffer u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_pkt_i    (w_dec_pkt),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_pkt_o   (w_out_pkt)
  );

  assign a_o       = w_out_pkt.a;
  assign b_o       = w_out_pkt.b;
  assign op_o      = w_out_pkt.op;
  assign rd_o      = w_out_pkt.rd;
  assign we_o      = w_out_pkt.we;
  assign illegal_o = w_out_pkt.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode cases, backpressure,
// flush, async reset and a randomized stream against a queue-based model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [3:0]  op_o;
  logic [4:0]  rd_o;
  logic        we_o;
  logic        illegal_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [74:0] got;
  assign got = {a_o, b_o, op_o, rd_o, we_o, illegal_o};

  alu_issue_stage #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .a_o(a_o), .b_o(b_o), .op_o(op_o), .rd_o(rd_o), .we_o(we_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic issue_pkt_t mk(input logic [31:0] a, input logic [31:0] b,
                                    input int op, input int rd, input bit we, input bit ill);
    issue_pkt_t p;
    p.a = a; p.b = b; p.op = alu_op_e'(op[3:0]); p.rd = rd[4:0]; p.we = we; p.illegal = ill;
    return p;
  endfunction

  // Reference decoder written directly from the instruction-set rules.
  function automatic issue_pkt_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                            input logic [31:0] rs1, input logic [31:0] rs2);
    int f3_op[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int opc = int'(instr[6:0]);
    int f3  = int'(instr[14:12]);
    int f7  = int'(instr[31:25]);
    int rd  = int'(instr[11:7]);
    int op_n = 0;
    bit ok = 0;
    logic [31:0] a = 0, b = 0;
    if (opc == 'h33) begin
      a = rs1; b = rs2; op_n = f3_op[f3];
      ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      if (f7 == 32) op_n = (f3 == 0) ? 1 : 7;
    end else if (opc == 'h13) begin
      a = rs1; b = 32'($signed(instr[31:20])); op_n = f3_op[f3]; ok = 1;
      if (f3 == 1) ok = (f7 == 0);
      if (f3 == 5) begin
        ok = (f7 == 0) || (f7 == 32);
        if (f7 == 32) op_n = 7;
      end
    end else if (opc == 'h37 || opc == 'h17) begin
      ok = 1; b = instr & 32'hFFFFF000; a = (opc == 'h17) ? pc : 32'd0;
    end
    if (!ok) begin a = 0; b = 0; op_n = 0; end
    if (op_n == 2 || op_n == 6 || op_n == 7) b = b % 32;
    return mk(a, b, op_n, rd, ok && rd != 0, !ok);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
    logic [6:0]  opc;
    logic [6:0]  f7;
    case ($urandom_range(0, 5))
      0, 2:    opc = 7'h33;
      1:       opc = 7'h13;
      3:       opc = 7'h37;
      4:       opc = 7'h17;
      default: opc = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      1:       f7 = 7'h20;
      2:       f7 = r[31:25];
      default: f7 = 7'h00;
    endcase
    return {f7, r[24:7], opc};
  endfunction

  task automatic idle_inputs();
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    instr_i = 32'd0; pc_i = 32'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #12;
    n_checks++;
    if ({out_valid_o, in_ready_o, got} !== {1'b0, 1'b1, 75'd0}) begin
      n_errors++;
      $display("FAIL reset_values: got v=%b r=%b pkt=%h, want v=0 r=1 pkt=0", out_valid_o, in_ready_o, got);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_errors++;
      $display("FAIL reset_release: got v=%b r=%b, want v=0 r=1", out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_decode_directed();
    logic [31:0] ins[6] = '{32'h002081B3, 32'h40435293, 32'h02431293, 32'h123450B7, 32'h00001097, 32'h00208033};
    logic [31:0] r1[6]  = '{32'd5, 32'hF0000000, 32'd9, 32'd3, 32'd3, 32'd5};
    issue_pkt_t  ex[6];
    ex[0] = mk(32'd5, 32'd7, 0, 3, 1'b1, 1'b0);
    ex[1] = mk(32'hF0000000, 32'd4, 7, 5, 1'b1, 1'b0);
    ex[2] = mk(32'd0, 32'd0, 0, 5, 1'b0, 1'b1);
    ex[3] = mk(32'd0, 32'h12345000, 0, 1, 1'b1, 1'b0);
    ex[4] = mk(32'h100, 32'h1000, 0, 1, 1'b1, 1'b0);
    ex[5] = mk(32'd5, 32'd7, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      in_valid_i = 1'b1; out_ready_i = 1'b1;
      instr_i = ins[i]; rs1_data_i = r1[i]; rs2_data_i = 32'd7; pc_i = 32'h100;
      @(posedge clk_i);
      #1;
      n_checks++;
      if (out_valid_o !== 1'b1 || got !== ex[i]) begin
        n_errors++;
        $display("FAIL decode_%0d: got v=%b pkt=%h, want v=1 pkt=%h", i, out_valid_o, got, ex[i]);
      end
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL decode_drain: got v=%b, want v=0", out_valid_o);
    end
  endtask

  task automatic fill_two_lui(input int base);
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n_checks++;
      if (in_ready_o !== (k < 2)) begin
        n_errors++;
        $display("FAIL fill_ready_%0d: got %b, want %b", k, in_ready_o, (k < 2));
      end
      in_valid_i = 1'b1;
      instr_i = ((base + k) << 12) | 32'h0B7;
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    fill_two_lui(1);
    for (int h = 0; h < 3; h++) begin
      n_checks++;
      if ({out_valid_o, in_ready_o} !== 2'b10 || got !== mk(32'd0, 32'h1000, 0, 1, 1'b1, 1'b0)) begin
        n_errors++;
        $display("FAIL hold_%0d: got v=%b r=%b pkt=%h, want v=1 r=0 b=1000", h, out_valid_o, in_ready_o, got);
      end
      @(negedge clk_i);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({out_valid_o, in_ready_o} !== 2'b11 || got !== mk(32'd0, 32'h2000, 0, 1, 1'b1, 1'b0)) begin
      n_errors++;
      $display("FAIL second_out: got v=%b r=%b pkt=%h, want v=1 r=1 b=2000", out_valid_o, in_ready_o, got);
    end
    @(negedge clk_i);
    n_checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_errors++;
      $display("FAIL third_dropped: got v=%b r=%b, want v=0 r=1", out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_flush();
    fill_two_lui(4);
    flush_i = 1'b1; in_valid_i = 1'b1; instr_i = 32'h002081B3;
    @(negedge clk_i);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    n_checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_errors++;
      $display("FAIL flush_two: got v=%b r=%b, want v=0 r=1", out_valid_o, in_ready_o);
    end
    in_valid_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_errors++;
      $display("FAIL flush_one_drop_input: got v=%b r=%b, want v=0 r=1", out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_random();
    issue_pkt_t q[$];
    bit in_fire, out_fire;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (out_valid_o !== (q.size() > 0) || in_ready_o !== (q.size() < 2) ||
          (q.size() > 0 && got !== q[0])) begin
        n_errors++;
        $display("FAIL random_cycle_%0d: got v=%b r=%b pkt=%h, want v=%b r=%b pkt=%h", c,
                 out_valid_o, in_ready_o, got, (q.size() > 0), (q.size() < 2),
                 (q.size() > 0) ? q[0] : '0);
      end
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 6);
      flush_i     = ($urandom_range(0, 29) == 0);
      instr_i = rand_instr(); pc_i = $urandom(); rs1_data_i = $urandom(); rs2_data_i = $urandom();
      in_fire  = in_valid_i && (q.size() < 2);
      out_fire = out_ready_i && (q.size() > 0);
      if (flush_i) begin
        q.delete();
      end else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) q.push_back(ref_decode(instr_i, pc_i, rs1_data_i, rs2_data_i));
      end
    end
    @(negedge clk_i);
    idle_inputs();
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  task automatic test_async_reset();
    fill_two_lui(7);
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({out_valid_o, in_ready_o, got} !== {1'b0, 1'b1, 75'd0}) begin
      n_errors++;
      $display("FAIL async_reset: got v=%b r=%b pkt=%h, want v=0 r=1 pkt=0", out_valid_o, in_ready_o, got);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_errors++;
      $display("FAIL after_async_reset: got v=%b r=%b, want v=0 r=1", out_valid_o, in_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_decode_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
